// File: rtl/sdf_pkg.sv
// Shared helpers for radix-2 SDF FFT stages: butterfly result scaling and
// output-index sizing.
package sdf_pkg;

   localparam int BF_MAXW = 64;

   typedef logic signed [BF_MAXW:0] bf_wide_t;

   function automatic int sdf_idx_w(input int depth);
      return (depth < 1) ? 1 : $clog2(2 * depth);
   endfunction

   // val is the sign-extended WIDTH+1-bit butterfly result; the caller keeps the low WIDTH bits
   function automatic bf_wide_t bf_scale(input bf_wide_t val, input logic scale, input logic rh);
      bf_wide_t t;
      t = val + $signed({{BF_MAXW{1'b0}}, rh});
      return scale ? (t >>> 1) : val;
   endfunction

endpackage

// File: rtl/sdf_delay_line.sv
// Complex feedback delay line for an SDF stage: fixed DEPTH-cycle latency,
// shifts every clock, no reset on the data.
module sdf_delay_line #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16
) (
   input  logic                    clock,
   input  logic signed [WIDTH-1:0] din_re,
   input  logic signed [WIDTH-1:0] din_im,
   output logic signed [WIDTH-1:0] dout_re,
   output logic signed [WIDTH-1:0] dout_im
);

   logic signed [WIDTH-1:0] sr_re [DEPTH];
   logic signed [WIDTH-1:0] sr_im [DEPTH];

   always_ff @(posedge clock) begin
      sr_re[0] <= din_re;
      sr_im[0] <= din_im;
      for (int i = 1; i < DEPTH; i++) begin
         sr_re[i] <= sr_re[i-1];
         sr_im[i] <= sr_im[i-1];
      end
   end

   assign dout_re = sr_re[DEPTH-1];
   assign dout_im = sr_im[DEPTH-1];

endmodule

// File: rtl/sdf_r2_stage.sv
// Radix-2 single-path delay-feedback FFT stage: emits x[n]+x[n+DEPTH] then
// x[n]-x[n+DEPTH] per frame, with optional halving and an output slot index.
module sdf_r2_stage
   import sdf_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4,
   parameter int SCALE = 0,
   parameter int BF_RH = 0
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic                       di_en,
   input  logic signed [WIDTH-1:0]    di_re,
   input  logic signed [WIDTH-1:0]    di_im,
   output logic                       do_en,
   output logic signed [WIDTH-1:0]    do_re,
   output logic signed [WIDTH-1:0]    do_im,
   output logic [$clog2(2*DEPTH)-1:0] do_idx
);

   localparam int   IW = sdf_idx_w(DEPTH);
   localparam logic SC = (SCALE != 0);
   localparam logic RH = (BF_RH != 0);

   logic [IW-1:0]           in_cnt;
   logic                    bf_act;
   logic signed [WIDTH-1:0] dl_in_re, dl_in_im;
   logic signed [WIDTH-1:0] dl_out_re, dl_out_im;
   logic signed [WIDTH-1:0] path_re, path_im;
   logic signed [WIDTH:0]   sum_re, sum_im, dif_re, dif_im;
   logic [DEPTH-1:0]        vld_p;

   function automatic logic signed [WIDTH-1:0] bf_f(input logic signed [WIDTH:0] v);
      bf_wide_t w;
      w = bf_scale($signed({{(BF_MAXW-WIDTH){v[WIDTH]}}, v}), SC, RH);
      return w[WIDTH-1:0];
   endfunction

   // Input stage: frame position and butterfly select
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         in_cnt <= '0;
      else if (!di_en)
         in_cnt <= '0;
      else
         in_cnt <= in_cnt + IW'(1);
   end

   assign bf_act = di_en & in_cnt[IW-1];

   assign sum_re = {dl_out_re[WIDTH-1], dl_out_re} + {di_re[WIDTH-1], di_re};
   assign sum_im = {dl_out_im[WIDTH-1], dl_out_im} + {di_im[WIDTH-1], di_im};
   assign dif_re = {dl_out_re[WIDTH-1], dl_out_re} - {di_re[WIDTH-1], di_re};
   assign dif_im = {dl_out_im[WIDTH-1], dl_out_im} - {di_im[WIDTH-1], di_im};

   // Differences are parked in the delay line and leave during the next frame's fill
   always_comb begin
      dl_in_re = di_re;
      dl_in_im = di_im;
      path_re  = dl_out_re;
      path_im  = dl_out_im;
      if (bf_act) begin
         dl_in_re = bf_f(dif_re);
         dl_in_im = bf_f(dif_im);
         path_re  = bf_f(sum_re);
         path_im  = bf_f(sum_im);
      end
   end

   sdf_delay_line #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) u_dl (
      .clock   (clock),
      .din_re  (dl_in_re),
      .din_im  (dl_in_im),
      .dout_re (dl_out_re),
      .dout_im (dl_out_im)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         vld_p <= '0;
      end else begin
         vld_p[0] <= di_en;
         for (int i = 1; i < DEPTH; i++)
            vld_p[i] <= vld_p[i-1];
      end
   end

   // Output stage: valid, slot index and data registered together
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         do_en  <= 1'b0;
         do_idx <= '0;
         do_re  <= '0;
         do_im  <= '0;
      end else begin
         do_en  <= vld_p[DEPTH-1];
         do_idx <= (vld_p[DEPTH-1] & do_en) ? do_idx + IW'(1) : '0;
         do_re  <= path_re;
         do_im  <= path_im;
      end
   end

endmodule

// File: tb/tb_sdf_r2_stage.sv
// Directed bench for sdf_r2_stage: DEPTH=4 with three scaling options,
// plus DEPTH=1 and DEPTH=16 instances.
module tb_sdf_r2_stage;

   logic clock   = 1'b0;
   logic reset_n = 1'b1;

   logic a_en = 1'b0; logic signed [15:0] a_re = '0, a_im = '0;
   logic b_en = 1'b0; logic signed [15:0] b_re = '0, b_im = '0;
   logic c_en = 1'b0; logic signed [15:0] c_re = '0, c_im = '0;

   logic s0_en, s1_en, r1_en, d1_en, d16_en;
   logic signed [15:0] s0_re, s0_im, s1_re, s1_im, r1_re, r1_im;
   logic signed [15:0] d1_re, d1_im, d16_re, d16_im;
   logic [2:0] s0_idx, s1_idx, r1_idx;
   logic [0:0] d1_idx;
   logic [4:0] d16_idx;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int start;

   typedef struct { int cyc; int re; int im; int idx; } rec_t;
   rec_t q_s0[$], q_s1[$], q_r1[$], q_d1[$], q_d16[$];

   int exp_f1[8]  = '{6, 8, 10, 12, -4, -4, -4, -4};
   int exp_f1s[8] = '{3, 4, 5, 6, -2, -2, -2, -2};
   int exp_b2b[16] = '{6, 8, 10, 12, -4, -4, -4, -4, 24, 26, 28, 30, -4, -4, -4, -4};
   int d1_in_re[6]  = '{3, -7, 100, 1, 32767, 1};
   int d1_in_im[6]  = '{5, 2, -1, -1, 0, 0};
   int d1_exp_re[6] = '{-4, 10, 101, 99, -32768, 32766};
   int d1_exp_im[6] = '{7, 3, -2, 0, 0, 0};

   always #5 clock = ~clock;

   sdf_r2_stage #(.WIDTH(16), .DEPTH(4), .SCALE(0), .BF_RH(0)) u_s0 (
      .clock(clock), .reset_n(reset_n), .di_en(a_en), .di_re(a_re), .di_im(a_im),
      .do_en(s0_en), .do_re(s0_re), .do_im(s0_im), .do_idx(s0_idx));
   sdf_r2_stage #(.WIDTH(16), .DEPTH(4), .SCALE(1), .BF_RH(0)) u_s1 (
      .clock(clock), .reset_n(reset_n), .di_en(a_en), .di_re(a_re), .di_im(a_im),
      .do_en(s1_en), .do_re(s1_re), .do_im(s1_im), .do_idx(s1_idx));
   sdf_r2_stage #(.WIDTH(16), .DEPTH(4), .SCALE(1), .BF_RH(1)) u_r1 (
      .clock(clock), .reset_n(reset_n), .di_en(a_en), .di_re(a_re), .di_im(a_im),
      .do_en(r1_en), .do_re(r1_re), .do_im(r1_im), .do_idx(r1_idx));
   sdf_r2_stage #(.WIDTH(16), .DEPTH(1), .SCALE(0), .BF_RH(0)) u_d1 (
      .clock(clock), .reset_n(reset_n), .di_en(b_en), .di_re(b_re), .di_im(b_im),
      .do_en(d1_en), .do_re(d1_re), .do_im(d1_im), .do_idx(d1_idx));
   sdf_r2_stage #(.WIDTH(16), .DEPTH(16), .SCALE(0), .BF_RH(0)) u_d16 (
      .clock(clock), .reset_n(reset_n), .di_en(c_en), .di_re(c_re), .di_im(c_im),
      .do_en(d16_en), .do_re(d16_re), .do_im(d16_im), .do_idx(d16_idx));

   always @(negedge clock) begin
      if (s0_en)  q_s0.push_back('{cyc, int'(s0_re), int'(s0_im), int'(s0_idx)});
      if (s1_en)  q_s1.push_back('{cyc, int'(s1_re), int'(s1_im), int'(s1_idx)});
      if (r1_en)  q_r1.push_back('{cyc, int'(r1_re), int'(r1_im), int'(r1_idx)});
      if (d1_en)  q_d1.push_back('{cyc, int'(d1_re), int'(d1_im), int'(d1_idx)});
      if (d16_en) q_d16.push_back('{cyc, int'(d16_re), int'(d16_im), int'(d16_idx)});
   end

   task automatic step();
      @(posedge clock);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic feed_a(input int re, input int im);
      a_en = 1'b1;
      a_re = 16'(re);
      a_im = 16'(im);
      step();
   endtask

   task automatic idle_a(input int n);
      a_en = 1'b0;
      a_re = '0;
      a_im = '0;
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic clear_q();
      q_s0.delete(); q_s1.delete(); q_r1.delete(); q_d1.delete(); q_d16.delete();
   endtask

   function automatic int xr(input int n);
      return 5 * n - 40;
   endfunction

   function automatic int xi(input int n);
      return 300 - 11 * n;
   endfunction

   initial begin
      #1 reset_n = 1'b0;

      // Reset held: outputs stay zero while inputs toggle
      for (int i = 0; i < 6; i++) begin
         a_en = i[0];
         a_re = 16'(i * 7 + 1);
         a_im = 16'(-i);
         step();
         chk("rst_en", int'(s0_en), 0);
         chk("rst_re", int'(s0_re), 0);
         chk("rst_im", int'(s0_im), 0);
         chk("rst_idx", int'(s0_idx), 0);
      end
      idle_a(1);
      reset_n = 1'b1;
      idle_a(2);

      // Frame 1..8 with all three scaling options
      clear_q();
      start = cyc;
      for (int n = 1; n <= 8; n++) feed_a(n, 0);
      idle_a(12);
      chk("f1_count", q_s0.size(), 8);
      for (int i = 0; i < 8; i++) begin
         chk("f1_cyc", q_s0[i].cyc, start + 5 + i);
         chk("f1_re", q_s0[i].re, exp_f1[i]);
         chk("f1_im", q_s0[i].im, 0);
         chk("f1_idx", q_s0[i].idx, i);
         chk("f1_s1_re", q_s1[i].re, exp_f1s[i]);
         chk("f1_r1_re", q_r1[i].re, exp_f1s[i]);
      end

      // Pair (1,2): floor vs round-half-up halving
      clear_q();
      for (int n = 0; n < 8; n++) feed_a((n < 4) ? 1 : 2, 0);
      idle_a(12);
      chk("pair_s0_sum", q_s0[0].re, 3);
      chk("pair_s0_dif", q_s0[4].re, -1);
      chk("pair_s1_sum", q_s1[0].re, 1);
      chk("pair_s1_dif", q_s1[4].re, -1);
      chk("pair_r1_sum", q_r1[0].re, 2);
      chk("pair_r1_dif", q_r1[4].re, 0);

      // Overflow wrap and scaled full-range results
      clear_q();
      for (int n = 0; n < 8; n++) feed_a((n < 4) ? 32767 : 1, (n < 4) ? -32768 : 1);
      idle_a(12);
      chk("wrap_sum_re", q_s0[0].re, -32768);
      chk("wrap_sum_im", q_s0[0].im, -32767);
      chk("wrap_dif_re", q_s0[4].re, 32766);
      chk("wrap_dif_im", q_s0[4].im, 32767);
      chk("wrap_s1_sum_re", q_s1[0].re, 16384);
      chk("wrap_s1_sum_im", q_s1[0].im, -16384);
      chk("wrap_s1_dif_re", q_s1[4].re, 16383);
      chk("wrap_s1_dif_im", q_s1[4].im, -16385);

      // Back-to-back frames 1..8 and 10..17
      clear_q();
      start = cyc;
      for (int n = 1; n <= 8; n++) feed_a(n, 0);
      for (int n = 10; n <= 17; n++) feed_a(n, 0);
      idle_a(12);
      chk("b2b_count", q_s0.size(), 16);
      for (int i = 0; i < 16; i++) begin
         chk("b2b_cyc", q_s0[i].cyc, start + 5 + i);
         chk("b2b_re", q_s0[i].re, exp_b2b[i]);
         chk("b2b_idx", q_s0[i].idx, i % 8);
      end

      // Partial frame, gap, then a complete frame
      clear_q();
      for (int n = 1; n <= 3; n++) feed_a(n, 0);
      idle_a(2);
      for (int n = 1; n <= 8; n++) feed_a(n, 0);
      idle_a(12);
      chk("abort_count", q_s0.size(), 11);
      chk("abort_gap", q_s0[3].cyc - q_s0[2].cyc, 3);
      chk("abort_pidx", q_s0[2].idx, 2);
      for (int i = 0; i < 8; i++) begin
         chk("abort_re", q_s0[3 + i].re, exp_f1[i]);
         chk("abort_idx", q_s0[3 + i].idx, i);
      end

      // Reset pulse at input sample 5, then a fresh frame
      for (int n = 1; n <= 5; n++) feed_a(n, 0);
      chk("prerst_en", int'(s0_en), 1);
      chk("prerst_re", int'(s0_re), 6);
      #2 reset_n = 1'b0;
      #1;
      chk("midrst_en", int'(s0_en), 0);
      chk("midrst_re", int'(s0_re), 0);
      chk("midrst_idx", int'(s0_idx), 0);
      chk("midrst_s1_en", int'(s1_en), 0);
      a_en = 1'b0;
      step();
      reset_n = 1'b1;
      idle_a(2);
      clear_q();
      start = cyc;
      for (int n = 1; n <= 8; n++) feed_a(n, 0);
      idle_a(12);
      chk("postrst_count", q_s0.size(), 8);
      for (int i = 0; i < 8; i++) begin
         chk("postrst_cyc", q_s0[i].cyc, start + 5 + i);
         chk("postrst_re", q_s0[i].re, exp_f1[i]);
      end

      // DEPTH=1: three contiguous two-sample frames
      clear_q();
      start = cyc;
      for (int n = 0; n < 6; n++) begin
         b_en = 1'b1;
         b_re = 16'(d1_in_re[n]);
         b_im = 16'(d1_in_im[n]);
         step();
      end
      b_en = 1'b0; b_re = '0; b_im = '0;
      for (int i = 0; i < 6; i++) step();
      chk("d1_count", q_d1.size(), 6);
      for (int i = 0; i < 6; i++) begin
         chk("d1_cyc", q_d1[i].cyc, start + 2 + i);
         chk("d1_re", q_d1[i].re, d1_exp_re[i]);
         chk("d1_im", q_d1[i].im, d1_exp_im[i]);
         chk("d1_idx", q_d1[i].idx, i % 2);
      end

      // DEPTH=16: one frame against the butterfly reference
      clear_q();
      start = cyc;
      for (int n = 0; n < 32; n++) begin
         c_en = 1'b1;
         c_re = 16'(xr(n));
         c_im = 16'(xi(n));
         step();
      end
      c_en = 1'b0; c_re = '0; c_im = '0;
      for (int i = 0; i < 40; i++) step();
      chk("d16_count", q_d16.size(), 32);
      for (int k = 0; k < 32; k++) begin
         chk("d16_cyc", q_d16[k].cyc, start + 17 + k);
         chk("d16_re", q_d16[k].re, (k < 16) ? xr(k) + xr(k + 16) : xr(k - 16) - xr(k));
         chk("d16_im", q_d16[k].im, (k < 16) ? xi(k) + xi(k + 16) : xi(k - 16) - xi(k));
         chk("d16_idx", q_d16[k].idx, k);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
